// File: rtl/uart_reg_responder.sv
// uart_reg_responder: decodes byte commands from a UART receiver into register bus accesses and replies with one byte per command
module uart_reg_responder #(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 500_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    input  logic                  rx_error,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  reg_wr,
    output logic                  reg_rd,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  busy,
    output logic [7:0]            err_count
);
    typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, REG_WRITE, REG_READ, READ_WAIT, SEND} state_t;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DATA_WIDTH-1:0] CMD_W = 8'h57;
    localparam logic [DATA_WIDTH-1:0] CMD_R = 8'h52;
    localparam logic [DATA_WIDTH-1:0] ACK   = 8'h06;
    localparam logic [DATA_WIDTH-1:0] NAK   = 8'h15;

    // The clock frequency only documents how TIMEOUT_CYCLES maps to real time.
    if (CLK_FREQ <= 0) begin : g_no_clock
    end

    state_t        state;
    logic          is_write;
    logic [TW-1:0] tcnt;
    logic          rx_st, waiting, expired, err_evt;

    // Classify the current cycle: which states listen to the receiver, and whether any error occurs.
    always_comb begin
        rx_st   = state == IDLE || state == GET_ADDR || state == GET_DATA;
        waiting = state == GET_ADDR || state == GET_DATA;
        expired = waiting && !rx_valid && !rx_error && tcnt == TW'(TIMEOUT_CYCLES - 1);
        err_evt = (rx_st && rx_error)
                || (state == IDLE && rx_valid && !rx_error && rx_data != CMD_W && rx_data != CMD_R)
                || expired
                || (!rx_st && rx_valid);
    end

    assign busy = state != IDLE;

    // Saturating error counter; at most one error source can fire per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_count <= '0;
        else if (err_evt && err_count != 8'hff) err_count <= err_count + 8'd1;
    end

    // Command FSM with registered bus strobes, reply byte and inter-byte timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            is_write  <= 1'b0;
            tcnt      <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
        end else begin
            reg_wr <= 1'b0;
            reg_rd <= 1'b0;
            tcnt   <= (waiting && !rx_valid && !expired) ? tcnt + TW'(1) : '0;
            case (state)
                IDLE: begin
                    if (rx_error || (rx_valid && rx_data != CMD_W && rx_data != CMD_R)) begin
                        tx_data  <= NAK;
                        tx_valid <= 1'b1;
                        state    <= SEND;
                    end else if (rx_valid) begin
                        is_write <= rx_data == CMD_W;
                        state    <= GET_ADDR;
                    end
                end
                GET_ADDR: begin
                    if (rx_error) begin
                        tx_data  <= NAK;
                        tx_valid <= 1'b1;
                        state    <= SEND;
                    end else if (rx_valid) begin
                        reg_addr <= ADDR_WIDTH'(rx_data);
                        reg_rd   <= !is_write;
                        state    <= is_write ? GET_DATA : REG_READ;
                    end else if (expired) begin
                        state <= IDLE;
                    end
                end
                GET_DATA: begin
                    if (rx_error) begin
                        tx_data  <= NAK;
                        tx_valid <= 1'b1;
                        state    <= SEND;
                    end else if (rx_valid) begin
                        reg_wdata <= rx_data;
                        reg_wr    <= 1'b1;
                        state     <= REG_WRITE;
                    end else if (expired) begin
                        state <= IDLE;
                    end
                end
                REG_WRITE: begin
                    tx_data  <= ACK;
                    tx_valid <= 1'b1;
                    state    <= SEND;
                end
                REG_READ: state <= READ_WAIT;
                READ_WAIT: begin
                    tx_data  <= reg_rdata;
                    tx_valid <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_reg_responder.sv
// tb_uart_reg_responder: randomized scoreboard bench for the UART register responder
module tb_uart_reg_responder;
    typedef struct packed {logic w; logic [7:0] a; logic [7:0] d;} bus_t;

    logic       clk = 0, rst = 1;
    logic [7:0] rx_data = 0, tx_data, reg_wdata, reg_rdata = 0, err_count;
    logic [7:0] reg_addr;
    logic       rx_valid = 0, rx_error = 0, tx_valid, tx_ready = 0, reg_wr, reg_rd, busy;

    int   total = 0, bad = 0, xfers = 0;
    int   rdy_mode = 0;
    logic [7:0] mem [256];
    logic [7:0] exp_mem [256];
    logic [7:0] exp_err = 0;
    logic [7:0] txq [$];
    bus_t       busq [$];

    uart_reg_responder #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_rdata(reg_rdata), .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Register slave: read data appears the cycle after reg_rd.
    always @(posedge clk) begin
        if (reg_rd) reg_rdata <= mem[reg_addr];
        if (reg_wr) mem[reg_addr] <= reg_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pop the scoreboards whenever the DUT presents a transfer or strobe.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            xfers++;
            if (txq.size() == 0) chk("tx_unexpected", {24'd0, tx_data}, 32'hffff_ffff);
            else chk("tx_byte", {24'd0, tx_data}, {24'd0, txq.pop_front()});
        end
        if (!rst && (reg_wr || reg_rd)) begin
            if (reg_wr && reg_rd) chk("wr_rd_overlap", 1, 0);
            else if (busq.size() == 0) chk("bus_unexpected", {15'd0, reg_wr, reg_addr, reg_wdata}, 32'hffff_ffff);
            else begin
                bus_t e;
                e = busq.pop_front();
                chk("bus_access", {15'd0, reg_wr, reg_addr, reg_wr ? reg_wdata : 8'h00}, {15'd0, e.w, e.a, e.d});
            end
        end
    end

    // Ready driver: random, held low, or held high.
    initial forever begin
        @(posedge clk);
        #1 tx_ready = rdy_mode == 0 ? 1'($urandom) : rdy_mode == 2;
    end

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return v == 8'hff ? v : v + 8'd1;
    endfunction

    task automatic rx_byte(input logic [7:0] b);
        @(posedge clk); #1 rx_data = b; rx_valid = 1;
        @(posedge clk); #1 rx_valid = 0;
    endtask

    task automatic rx_err_pulse();
        @(posedge clk); #1 rx_error = 1;
        @(posedge clk); #1 rx_error = 0;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 3)) @(posedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            @(posedge clk); #1 n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic wait_tx_valid();
        int n = 0;
        while (!tx_valid && n < 50) begin
            @(posedge clk); #1 n++;
        end
        if (!tx_valid) chk("tx_valid_timeout", 0, 1);
    endtask

    function automatic logic [7:0] bad_cmd();
        logic [7:0] b = 8'($urandom);
        while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
        return b;
    endfunction

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        exp_mem[a] = d;
        busq.push_back({1'b1, a, d});
        txq.push_back(8'h06);
        rx_byte(8'h57); gap(); rx_byte(a); gap(); rx_byte(d);
    endtask

    task automatic do_read(input logic [7:0] a);
        busq.push_back({1'b0, a, 8'h00});
        txq.push_back(exp_mem[a]);
        rx_byte(8'h52); gap(); rx_byte(a);
    endtask

    task automatic do_bad(input logic [7:0] b);
        exp_err = sat_inc(exp_err);
        txq.push_back(8'h15);
        rx_byte(b);
    endtask

    initial begin
        logic [7:0] held, a, d;
        logic stable;
        int cnt;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            exp_mem[i] = mem[i];
        end
        repeat (3) @(posedge clk);
        #3 rst = 0;
        #1;
        chk("reset_tx_valid", tx_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_err", err_count, 0);
        chk("reset_tx_data", tx_data, 0);
        chk("reset_strobes", {reg_wr, reg_rd, reg_addr, reg_wdata}, 0);

        // Directed write with latency
        exp_mem[8'h12] = 8'hA5;
        busq.push_back({1'b1, 8'h12, 8'hA5});
        txq.push_back(8'h06);
        rx_byte(8'h57); rx_byte(8'h12); rx_byte(8'hA5);
        chk("write_wr_n1", {reg_wr, tx_valid}, 2'b10);
        @(posedge clk); #1 chk("write_txv_n2", {reg_wr, tx_valid}, 2'b01);
        wait_idle();
        chk("write_err", err_count, 0);

        // Directed read with latency
        mem[8'h34] = 8'h5C; exp_mem[8'h34] = 8'h5C;
        busq.push_back({1'b0, 8'h34, 8'h00});
        txq.push_back(8'h5C);
        rx_byte(8'h52); rx_byte(8'h34);
        chk("read_rd_n1", {reg_rd, reg_wr, tx_valid}, 3'b100);
        @(posedge clk); #1 chk("read_txv_n2", {reg_rd, tx_valid}, 2'b00);
        @(posedge clk); #1 chk("read_txv_n3", tx_valid, 1);
        wait_idle();

        // Unknown command: NAK next cycle, then saturation
        do_bad(8'h41);
        chk("nak_txv_n1", tx_valid, 1);
        wait_idle();
        chk("nak_err1", err_count, 1);
        for (int i = 0; i < 299; i++) begin
            do_bad(8'h41);
            wait_idle();
        end
        chk("err_saturated", err_count, 255);
        chk("err_model", err_count, {24'd0, exp_err});

        // Timeout then a normal read
        rst = 1; #1 rst = 0; exp_err = 0; txq.delete(); busq.delete();
        rx_byte(8'h57);
        cnt = 0;
        while (busy && cnt < 200) begin
            @(posedge clk); #1 cnt++;
        end
        exp_err = sat_inc(exp_err);
        chk("timeout_cycles", cnt, 100);
        chk("timeout_err", err_count, {24'd0, exp_err});
        do_read(8'h00);
        wait_idle();

        // Backpressure with an overrun byte
        rdy_mode = 1;
        do_read(8'h77);
        wait_tx_valid();
        held = tx_data;
        stable = 1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (!tx_valid || tx_data !== held) stable = 0;
            if (i == 20) begin rx_data = 8'($urandom); rx_valid = 1; exp_err = sat_inc(exp_err); end
            if (i == 21) rx_valid = 0;
        end
        chk("bp_stable", stable, 1);
        chk("bp_overrun_err", err_count, {24'd0, exp_err});
        cnt = xfers;
        rdy_mode = 2;
        wait_idle();
        chk("bp_one_transfer", xfers - cnt, 1);
        rdy_mode = 0;

        // Abort in GET_DATA
        rx_byte(8'h57); rx_byte(8'h09);
        exp_err = sat_inc(exp_err);
        txq.push_back(8'h15);
        rx_err_pulse();
        chk("abort_nak", {tx_valid, tx_data}, 9'h115);
        wait_idle();
        chk("abort_err", err_count, {24'd0, exp_err});

        // Reset while in SEND
        rdy_mode = 1;
        do_bad(8'h99);
        wait_tx_valid();
        #2 rst = 1;
        #1 chk("rst_send", {tx_valid, busy, err_count}, 0);
        txq.delete(); exp_err = 0;
        @(posedge clk); #3 rst = 0;
        rdy_mode = 0;

        // Randomized command mix
        for (int k = 0; k < 150; k++) begin
            a = 8'($urandom); d = 8'($urandom);
            case ($urandom_range(0, 4))
                0: do_write(a, d);
                1: do_read(a);
                2: do_bad(bad_cmd());
                3: begin
                    exp_err = sat_inc(exp_err);
                    txq.push_back(8'h15);
                    if ($urandom_range(0, 1) == 1) begin
                        rx_byte(8'h57); gap(); rx_byte(a);
                    end else rx_byte(8'h52);
                    gap(); rx_err_pulse();
                end
                default: begin
                    rdy_mode = 1;
                    do_bad(bad_cmd());
                    wait_tx_valid();
                    exp_err = sat_inc(exp_err);
                    rx_byte(d);
                    rdy_mode = 0;
                end
            endcase
            wait_idle();
            if (k % 10 == 0) chk("rand_err", err_count, {24'd0, exp_err});
        end
        repeat (3) @(posedge clk); #1;
        chk("final_err", err_count, {24'd0, exp_err});
        chk("txq_empty", txq.size(), 0);
        chk("busq_empty", busq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
